fetch_cycle: RTL

//  IF stage of the 5-stage RV32I pipeline: owns PC_F, issues word fetches over a valid/ready imem port, buffers responses in a

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 91 +++++++++
 rtl/fetch_cycle.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I fetch stage.
//   XLEN             : architectural register / address width
//   NOP_INSTR        : canonical NOP (addi x0,x0,0) loaded as a bubble into IF/ID
//   RESET_PC_DEFAULT : default PC after reset
//   fetch_entry_t    : prefetch queue entry {pc, instr}
//   fetch_tag_t      : in-flight request tag {pc, epoch}
package riscv_pkg;

  localparam int               XLEN             = 32;
  localparam logic [XLEN-1:0]  NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            epoch;
  } fetch_tag_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used by the fetch stage for both the in-flight
// tag queue and the prefetch queue. DEPTH must be a power of two so the
// read/write pointers can wrap naturally.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push/wdata : enqueue (ignored when full unless a pop happens the same cycle)
//   pop/rdata  : dequeue, rdata shows the head (pop on empty is ignored)
//   clear      : drop all entries; wins over push and pop
//   count      : number of stored entries
//   full/empty : status flags
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A full queue may still accept a push when the head leaves in the same
  // cycle, since the freed slot is the one being written.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state is reset; storage contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Popping an empty queue or overfilling it indicates a protocol error
  // upstream; the request is ignored but flagged in simulation.
  assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !clear));

endmodule

// File: rtl/fetch_cycle.sv
// IF stage of the 5-stage RV32I pipeline. Owns PC_F, issues word fetches
// over a valid/ready instruction memory port, buffers in-order responses in
// a prefetch queue and drives the IF/ID register.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   Stall_F                        : block new fetch requests
//   Stall_D, Flush_D               : hold / bubble the IF/ID register (flush wins)
//   PCSrc_E, PCTarget_E            : redirect from EX
//   imem_req_valid/ready/addr      : fetch request channel (addr = PC_F)
//   imem_rsp_valid/data            : in-order response channel, no backpressure
//   Instr_D, PC_D, PCPlus4_D, Valid_D : IF/ID register outputs
// Optional feature macro IF_PERF_CNT_EN adds fetch_cnt, bubble_cnt and
// stale_cnt performance counters.
module fetch_cycle
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic        PCSrc_E,
  input  logic [31:0] PCTarget_E,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] stale_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic            epoch_q, epoch_d;
  logic [XLEN-1:0] instr_d_q, instr_d_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic [XLEN-1:0] pcplus4_d_q, pcplus4_d_d;
  logic            valid_d_q, valid_d_d;

  fetch_tag_t   tag_wdata, tag_rdata;
  fetch_entry_t pf_wdata, pf_rdata;
  logic [CW-1:0] tag_cnt, pf_cnt;
  logic          tag_full, tag_empty, pf_full, pf_empty;
  logic [CW:0]   inflight;
  logic          credit_ok, req_fire, rsp_fire, rsp_fresh, load_en, pf_pop;
  logic          unused_target_lsbs;

  // Target bits [1:0] are forced to zero on a redirect.
  assign unused_target_lsbs = ^PCTarget_E[1:0];

  // Every fetch holds one credit from request until it leaves the prefetch
  // queue, so neither queue can overflow. With a 1-cycle memory each fetch
  // holds its credit for two cycles, which caps a depth-2 queue below one
  // fetch per cycle.
  assign inflight  = {1'b0, tag_cnt} + {1'b0, pf_cnt};
  assign credit_ok = ~tag_full & ~pf_full & (inflight < (CW + 1)'(FIFO_DEPTH));

  assign imem_req_valid = ~rst & ~Stall_F & ~PCSrc_E & credit_ok;
  assign imem_req_addr  = pc_f_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses tagged with an older epoch belong to a fetch path that a
  // redirect abandoned, so they are dropped instead of being queued.
  assign rsp_fire  = imem_rsp_valid & ~tag_empty;
  assign rsp_fresh = rsp_fire & (tag_rdata.epoch == epoch_q);

  assign load_en = ~Flush_D & ~Stall_D;
  assign pf_pop  = load_en & ~pf_empty;

  assign tag_wdata = '{pc: pc_f_q, epoch: epoch_q};
  assign pf_wdata  = '{pc: tag_rdata.pc, instr: imem_rsp_data};

  fetch_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .wdata (tag_wdata),
    .pop   (imem_rsp_valid),
    .rdata (tag_rdata),
    .clear (1'b0),
    .count (tag_cnt),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_pf_q (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_fresh),
    .wdata (pf_wdata),
    .pop   (pf_pop),
    .rdata (pf_rdata),
    .clear (PCSrc_E),
    .count (pf_cnt),
    .full  (pf_full),
    .empty (pf_empty)
  );

  // PC and epoch: a redirect overrides any same-cycle handshake advance.
  always_comb begin
    pc_f_d  = pc_f_q;
    epoch_d = epoch_q;
    if (PCSrc_E) begin
      pc_f_d  = {PCTarget_E[31:2], 2'b00};
      epoch_d = ~epoch_q;
    end else if (req_fire) begin
      pc_f_d = pc_f_q + 32'd4;
    end
  end

  // IF/ID register: flush beats stall beats load; loading from an empty
  // prefetch queue inserts a bubble.
  always_comb begin
    instr_d_d   = instr_d_q;
    pc_d_d      = pc_d_q;
    pcplus4_d_d = pcplus4_d_q;
    valid_d_d   = valid_d_q;
    if (Flush_D || (load_en && pf_empty)) begin
      instr_d_d   = NOP_INSTR;
      pc_d_d      = '0;
      pcplus4_d_d = '0;
      valid_d_d   = 1'b0;
    end else if (load_en) begin
      instr_d_d   = pf_rdata.instr;
      pc_d_d      = pf_rdata.pc;
      pcplus4_d_d = pf_rdata.pc + 32'd4;
      valid_d_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q      <= RESET_PC;
      epoch_q     <= 1'b0;
      instr_d_q   <= NOP_INSTR;
      pc_d_q      <= '0;
      pcplus4_d_q <= '0;
      valid_d_q   <= 1'b0;
    end else begin
      pc_f_q      <= pc_f_d;
      epoch_q     <= epoch_d;
      instr_d_q   <= instr_d_d;
      pc_d_q      <= pc_d_d;
      pcplus4_d_q <= pcplus4_d_d;
      valid_d_q   <= valid_d_d;
    end
  end

  assign Instr_D   = instr_d_q;
  assign PC_D      = pc_d_q;
  assign PCPlus4_D = pcplus4_d_q;
  assign Valid_D   = valid_d_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stale_cnt_q, stale_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + 32'(pf_pop);
    bubble_cnt_d = bubble_cnt_q + 32'(load_en & pf_empty);
    stale_cnt_d  = stale_cnt_q + 32'(rsp_fire & ~rsp_fresh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      stale_cnt_q  <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      stale_cnt_q  <= stale_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign stale_cnt  = stale_cnt_q;
`endif

endmodule
